// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C master sequencer: orders START, address byte, N data bytes and STOP
// around an external bit engine and an external down-counting byte counter.
module i2c_byte_sequencer #(
  parameter bit ADDR_ACK_CHECK = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic rw_mode,
  input  logic abort,
  output logic load_buffer,
  output logic decrement,
  input  logic zero,
  output logic gen_start,
  output logic gen_stop,
  input  logic cond_done,
  output logic byte_start,
  output logic addr_phase,
  output logic send_ack,
  input  logic byte_done,
  input  logic ack_rcvd,
  output logic busy,
  output logic done,
  output logic nack_err
);

  typedef enum logic [3:0] {
    IDLE, LOAD, START, ADDR, ADDR_WAIT, DEC, CHECK, XFER, XFER_WAIT, STOP
  } state_t;

  state_t state_q, state_d;
  logic   rw_q, nack_q, last_q, ack_q, abort_q, cond_sent_q;
  logic   set_err, abort_any;

  // An abort seen earlier is remembered so it takes effect at the next safe point.
  assign abort_any = abort | abort_q;

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      IDLE:      if (start) state_d = LOAD;
      LOAD:      state_d = abort ? IDLE : START;
      START:     if (cond_sent_q && cond_done) state_d = abort_any ? STOP : ADDR;
      ADDR:      state_d = ADDR_WAIT;
      ADDR_WAIT: if (byte_done) begin
        if (ack_rcvd && ADDR_ACK_CHECK) begin
          set_err = 1'b1;
          state_d = STOP;
        end else begin
          state_d = abort_any ? STOP : DEC;
        end
      end
      DEC:       state_d = abort_any ? STOP : CHECK;
      CHECK:     state_d = abort_any ? STOP : XFER;
      XFER:      state_d = XFER_WAIT;
      XFER_WAIT: if (byte_done) begin
        // Byte result is evaluated before a coincident abort is honoured.
        if (!rw_q && ack_rcvd) begin
          set_err = 1'b1;
          state_d = STOP;
        end else begin
          state_d = (last_q || abort_any) ? STOP : DEC;
        end
      end
      STOP:      if (cond_sent_q && cond_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      last_q      <= 1'b0;
      ack_q       <= 1'b1;
      abort_q     <= 1'b0;
      cond_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Marks that the START/STOP request for the current state was already issued.
      cond_sent_q <= (state_d == state_q) && (state_q == START || state_q == STOP);
      if (state_q == IDLE && start) begin
        rw_q   <= rw_mode;
        nack_q <= 1'b0;
      end else if (set_err) begin
        nack_q <= 1'b1;
      end
      if (state_q == IDLE)
        abort_q <= 1'b0;
      else if (abort && state_q inside {START, ADDR, ADDR_WAIT, DEC, CHECK, XFER, XFER_WAIT})
        abort_q <= 1'b1;
      if (state_q == LOAD)       last_q <= 1'b0;
      else if (state_q == CHECK) last_q <= zero;
      if (state_q == XFER)       ack_q <= !last_q;
      else if (state_q == IDLE)  ack_q <= 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held, even before the state register clears.
  always_comb begin
    load_buffer = !rst && state_q == LOAD;
    decrement   = !rst && state_q == DEC;
    gen_start   = !rst && state_q == START && !cond_sent_q;
    gen_stop    = !rst && state_q == STOP && !cond_sent_q;
    byte_start  = !rst && (state_q == ADDR || state_q == XFER);
    addr_phase  = !rst && (state_q == ADDR || state_q == ADDR_WAIT);
    busy        = !rst && state_q != IDLE;
    done        = !rst && ((state_q == STOP && cond_sent_q && cond_done) ||
                           (state_q == LOAD && abort));
    nack_err    = !rst && nack_q;
    send_ack    = rst ? 1'b1 : (state_q == XFER) ? !last_q : ack_q;
  end

endmodule

// File: doc/i2c_byte_sequencer.md
I2C_BYTE_SEQUENCER -- requirements
Module: i2c_byte_sequencer

Interface
REQ-001 SHALL have parameter ADDR_ACK_CHECK, default 1: 1 = NACK on the address byte ends the transfer with an error; 0 = address NACK ignored.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: single-cycle request to begin a transaction; honoured only in IDLE.
REQ-005 SHALL have port rw_mode, input, 1: 1 = read, 0 = write; sampled with start.
REQ-006 SHALL have port abort, input, 1: request to end the current transaction early.
REQ-007 SHALL have port load_buffer, output, 1: load strobe to the byte counter.
REQ-008 SHALL have port decrement, output, 1: decrement strobe to the byte counter.
REQ-009 SHALL have port zero, input, 1: byte counter empty flag; valid in the cycle after a load_buffer or decrement strobe.
REQ-010 SHALL have port gen_start, output, 1: pulse requesting a START condition from the bit engine.
REQ-011 SHALL have port gen_stop, output, 1: pulse requesting a STOP condition from the bit engine.
REQ-012 SHALL have port cond_done, input, 1: bit engine finished the requested START or STOP.
REQ-013 SHALL have port byte_start, output, 1: pulse requesting one 8-bit transfer plus ACK slot.
REQ-014 SHALL have port addr_phase, output, 1: high while the address byte is in flight.
REQ-015 SHALL have port send_ack, output, 1: master ACK for the current read byte; 1 = ACK, 0 = NACK.
REQ-016 SHALL have port byte_done, input, 1: bit engine finished the byte and the ACK slot.
REQ-017 SHALL have port ack_rcvd, input, 1: slave ACK level, qualified by byte_done; 0 = ACK, 1 = NACK.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-019 SHALL have port done, output, 1: single-cycle pulse when a transaction ends.
REQ-020 SHALL have port nack_err, output, 1: sticky error flag; cleared by an accepted start.

Function
REQ-021 SHALL implement the states IDLE, LOAD, START, ADDR, ADDR_WAIT, DEC, CHECK, XFER, XFER_WAIT, STOP.
REQ-022 IDLE SHALL go to LOAD on start, latch rw_mode and clear nack_err.
REQ-023 LOAD SHALL assert load_buffer for exactly one cycle and then go to START.
REQ-024 START SHALL pulse gen_start in its first cycle, then wait for cond_done and go to ADDR.
REQ-025 ADDR SHALL pulse byte_start with addr_phase=1 and go to ADDR_WAIT.
REQ-026 ADDR_WAIT SHALL hold addr_phase=1 until byte_done.
REQ-027 In ADDR_WAIT on byte_done: if ack_rcvd=1 and ADDR_ACK_CHECK=1, SHALL set nack_err and go to STOP; otherwise SHALL go to DEC.
REQ-028 DEC SHALL assert decrement for exactly one cycle and then go to CHECK.
REQ-029 CHECK SHALL register last_flag = zero and then go to XFER.
REQ-030 XFER SHALL pulse byte_start and drive send_ack = !last_flag; send_ack SHALL hold that value through XFER_WAIT.
REQ-031 In XFER_WAIT on byte_done: write mode with ack_rcvd=1 SHALL set nack_err and go to STOP.
REQ-032 In XFER_WAIT on byte_done: if last_flag=1, SHALL go to STOP; otherwise SHALL go to DEC.
REQ-033 Packet length L (1..63) SHALL produce exactly L decrement strobes and L data byte_start pulses.
REQ-034 Packet length 0 SHALL be treated as 64 bytes, using the counter's zero semantics only.
REQ-035 STOP SHALL pulse gen_stop in its first cycle, then wait for cond_done.
REQ-036 On cond_done in STOP, SHALL pulse done and go to IDLE.
REQ-037 Every strobe (load_buffer, decrement, gen_start, gen_stop, byte_start, done) SHALL be exactly one cycle wide.
REQ-038 abort in LOAD SHALL go to IDLE with a done pulse and no gen_start.
REQ-039 abort in START, ADDR, ADDR_WAIT, DEC, CHECK, XFER or XFER_WAIT SHALL finish any in-flight byte (wait for byte_done) and then go to STOP.
REQ-040 abort in STOP or IDLE SHALL be ignored.
REQ-041 start while busy SHALL be ignored.
REQ-042 If byte_done arrives in the same cycle as abort, byte_done SHALL be processed first (ACK checks apply) and the next state SHALL be STOP.

Reset
REQ-043 rst=1 at a clock edge SHALL force IDLE from any state, including mid-byte.
REQ-044 During and after reset, all strobes SHALL be 0.
REQ-045 During and after reset, busy, nack_err, addr_phase and last_flag SHALL be 0, and send_ack SHALL be 1.
REQ-046 Reset SHALL NOT generate gen_stop.

Verification
REQ-047 Write, L=3, all ACK -> 1 load_buffer, 1 gen_start, 4 byte_start (first with addr_phase), 3 decrement, 1 gen_stop, 1 done; nack_err=0.
REQ-048 Read, L=2 -> first data byte send_ack=1, second data byte send_ack=0, then STOP; L=1 -> the only data byte has send_ack=0.
REQ-049 L=0 -> exactly 64 data bytes and 64 decrement strobes before gen_stop.
REQ-050 Address NACK with ADDR_ACK_CHECK=1 -> nack_err=1, no decrement, gen_stop, done; a new start then clears nack_err.
REQ-051 Write, L=5, NACK on data byte 2 -> gen_stop after byte 2, only 2 decrement strobes, nack_err=1.
REQ-052 abort during XFER_WAIT of byte 2 -> byte completes, gen_stop, done; rst asserted mid-ADDR_WAIT -> IDLE next cycle, busy=0, no gen_stop.
